// File: rtl/cluster_count_monitor.sv
// cluster_count_monitor
//   Consumes the per-sample cluster count from the VPF cluster counter. For each valid sample it
//   flags overflow against THRESH, tracks peak occupancy and overflow events, tags the sample with
//   a 12-bit bunch-crossing number and, optionally, queues {bx_tag, count} records into a small
//   FIFO drained through a valid/ready handshake.
//
//   Optional feature macro: CLUSTER_COUNT_RECORD_FIFO_EN
//     defined   : record FIFO, handshake and drop counter are built.
//     undefined : no FIFO storage; rec_valid_o, rec_data_o and drop_events_o tie to 0 and
//                 rec_ready_i is ignored.
//
// Ports
//   clock4x           sole clock
//   reset             asynchronous active-high reset
//   cnt_i             cluster count sample
//   cnt_valid_i       cnt_i is a new sample this cycle
//   bc0_i             BX-zero marker
//   clear_i           synchronous clear of sticky, peak and event counters
//   overflow_o        last sample exceeded THRESH
//   overflow_sticky_o any overflow since reset/clear
//   max_cnt_o         peak count since reset/clear
//   ovf_events_o      overflowing samples, saturating
//   drop_events_o     records lost to a full FIFO, saturating
//   rec_data_o        record {bx_tag[11:0], count}
//   rec_valid_o       record available
//   rec_ready_i       consumer accepts record
module cluster_count_monitor #(
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned THRESH     = 8,
  parameter int unsigned REC_MIN    = 1,
  parameter int unsigned BX_MAX     = 3563,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned EVT_W      = 16
) (
  input  logic                clock4x,
  input  logic                reset,
  input  logic [CNT_W-1:0]    cnt_i,
  input  logic                cnt_valid_i,
  input  logic                bc0_i,
  input  logic                clear_i,
  output logic                overflow_o,
  output logic                overflow_sticky_o,
  output logic [CNT_W-1:0]    max_cnt_o,
  output logic [EVT_W-1:0]    ovf_events_o,
  output logic [EVT_W-1:0]    drop_events_o,
  output logic [12+CNT_W-1:0] rec_data_o,
  output logic                rec_valid_o,
  input  logic                rec_ready_i
);

  localparam int unsigned REC_W = 12 + CNT_W;

  localparam logic [CNT_W-1:0] ThreshC = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] RecMinC = CNT_W'(REC_MIN);
  localparam logic [11:0]      BxMaxC  = 12'(BX_MAX);

  // bx_q holds the tag the next sample will receive unless bc0_i overrides it.
  logic [11:0]      bx_q, bx_d;
  logic [11:0]      tag;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [EVT_W-1:0] ovf_evt_q, ovf_evt_d;
  logic             is_ovf;
  logic             rec_push;

  always_comb begin
    tag       = bc0_i ? 12'd0 : bx_q;
    is_ovf    = cnt_i > ThreshC;
    rec_push  = cnt_valid_i && (cnt_i >= RecMinC);

    bx_d      = bx_q;
    ovf_d     = ovf_q;
    sticky_d  = sticky_q;
    max_d     = max_q;
    ovf_evt_d = ovf_evt_q;

    if (cnt_valid_i) begin
      bx_d = (tag == BxMaxC) ? 12'd0 : tag + 12'd1;
    end else if (bc0_i) begin
      bx_d = 12'd0;
    end

    // Clear first, then apply a coincident sample on top of the cleared state.
    if (clear_i) begin
      sticky_d  = 1'b0;
      max_d     = '0;
      ovf_evt_d = '0;
    end

    if (cnt_valid_i) begin
      ovf_d = is_ovf;
      if (is_ovf) begin
        sticky_d = 1'b1;
        if (ovf_evt_d != '1) begin
          ovf_evt_d = ovf_evt_d + EVT_W'(1);
        end
      end
      if (cnt_i > max_d) begin
        max_d = cnt_i;
      end
    end
  end

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      bx_q      <= '0;
      ovf_q     <= 1'b0;
      sticky_q  <= 1'b0;
      max_q     <= '0;
      ovf_evt_q <= '0;
    end else begin
      bx_q      <= bx_d;
      ovf_q     <= ovf_d;
      sticky_q  <= sticky_d;
      max_q     <= max_d;
      ovf_evt_q <= ovf_evt_d;
    end
  end

  assign overflow_o        = ovf_q;
  assign overflow_sticky_o = sticky_q;
  assign max_cnt_o         = max_q;
  assign ovf_events_o      = ovf_evt_q;

`ifdef CLUSTER_COUNT_RECORD_FIFO_EN
  // Pointers carry one extra bit so full and empty are distinguishable by wr - rd.
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;

  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] occ;
  logic [EVT_W-1:0] drop_q, drop_d;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_en;
  logic             drop;

  always_comb begin
    occ     = wr_q - rd_q;
    full    = (occ == PTR_W'(FIFO_DEPTH));
    empty   = (occ == '0);
    pop     = !empty && rec_ready_i;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    push_en = rec_push && (!full || pop);
    drop    = rec_push && full && !pop;

    wr_d    = push_en ? wr_q + PTR_W'(1) : wr_q;
    rd_d    = pop ? rd_q + PTR_W'(1) : rd_q;

    drop_d  = clear_i ? '0 : drop_q;
    if (drop && (drop_d != '1)) begin
      drop_d = drop_d + EVT_W'(1);
    end
  end

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      drop_q <= drop_d;
    end
  end

  // Storage needs no reset: entries are only observable once the write pointer passes them.
  always_ff @(posedge clock4x) begin
    if (push_en) begin
      mem_q[wr_q[PTR_W-2:0]] <= {tag, cnt_i};
    end
  end

  assign rec_valid_o   = !empty;
  assign rec_data_o    = empty ? '0 : mem_q[rd_q[PTR_W-2:0]];
  assign drop_events_o = drop_q;
`else
  logic unused_fifo_inputs;
  assign unused_fifo_inputs = rec_ready_i ^ rec_push;

  assign rec_valid_o   = 1'b0;
  assign rec_data_o    = '0;
  assign drop_events_o = '0;
`endif

endmodule

// File: tb/tb_cluster_count_monitor.sv
module tb_cluster_count_monitor;

  localparam int CNT_W      = 11;
  localparam int THRESH     = 8;
  localparam int REC_MIN    = 1;
  localparam int BX_MAX     = 3563;
  localparam int FIFO_DEPTH = 8;
  localparam int EVT_W      = 16;
  localparam int EVT_MAX    = (1 << EVT_W) - 1;
  localparam int REC_W      = 12 + CNT_W;

`ifdef CLUSTER_COUNT_RECORD_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic               clock4x = 1'b0;
  logic               reset   = 1'b0;
  logic [CNT_W-1:0]   cnt_i   = '0;
  logic               cnt_valid_i = 1'b0;
  logic               bc0_i   = 1'b0;
  logic               clear_i = 1'b0;
  logic               rec_ready_i = 1'b0;
  logic               overflow_o;
  logic               overflow_sticky_o;
  logic [CNT_W-1:0]   max_cnt_o;
  logic [EVT_W-1:0]   ovf_events_o;
  logic [EVT_W-1:0]   drop_events_o;
  logic [REC_W-1:0]   rec_data_o;
  logic               rec_valid_o;

  cluster_count_monitor #(
    .CNT_W     (CNT_W),
    .THRESH    (THRESH),
    .REC_MIN   (REC_MIN),
    .BX_MAX    (BX_MAX),
    .FIFO_DEPTH(FIFO_DEPTH),
    .EVT_W     (EVT_W)
  ) dut (
    .clock4x          (clock4x),
    .reset            (reset),
    .cnt_i            (cnt_i),
    .cnt_valid_i      (cnt_valid_i),
    .bc0_i            (bc0_i),
    .clear_i          (clear_i),
    .overflow_o       (overflow_o),
    .overflow_sticky_o(overflow_sticky_o),
    .max_cnt_o        (max_cnt_o),
    .ovf_events_o     (ovf_events_o),
    .drop_events_o    (drop_events_o),
    .rec_data_o       (rec_data_o),
    .rec_valid_o      (rec_valid_o),
    .rec_ready_i      (rec_ready_i)
  );

  always #5 clock4x = ~clock4x;

  // Behavioural reference state.
  int               m_bx;      // tag the next sample receives
  bit               m_ovf;
  bit               m_sticky;
  int               m_max;
  int               m_oev;
  int               m_dev;
  logic [REC_W-1:0] m_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_bx = 0; m_ovf = 0; m_sticky = 0; m_max = 0; m_oev = 0; m_dev = 0;
    m_q.delete();
  endtask

  task automatic model_step(input int cnt, input bit v, input bit bc0, input bit clr,
                            input bit rdy);
    int tag;
    bit pop;
    bit push;
    pop  = FIFO_EN && (m_q.size() > 0) && rdy;
    push = 0;
    if (clr) begin
      m_sticky = 0; m_max = 0; m_oev = 0; m_dev = 0;
    end
    if (v) begin
      tag   = bc0 ? 0 : m_bx;
      m_bx  = (tag == BX_MAX) ? 0 : tag + 1;
      m_ovf = cnt > THRESH;
      if (m_ovf) begin
        m_sticky = 1;
        if (m_oev < EVT_MAX) m_oev++;
      end
      if (cnt > m_max) m_max = cnt;
      push = FIFO_EN && (cnt >= REC_MIN);
    end else if (bc0) begin
      m_bx = 0;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < FIFO_DEPTH) m_q.push_back({12'(tag), 11'(cnt)});
      else if (m_dev < EVT_MAX) m_dev++;
    end
  endtask

  // Full comparison of every output against the model.
  task automatic compare();
    logic [REC_W-1:0] exp_data;
    exp_data = (m_q.size() > 0) ? m_q[0] : '0;
    chk("overflow_o", 64'(overflow_o), 64'(m_ovf));
    chk("overflow_sticky_o", 64'(overflow_sticky_o), 64'(m_sticky));
    chk("max_cnt_o", 64'(max_cnt_o), 64'(m_max));
    chk("ovf_events_o", 64'(ovf_events_o), 64'(m_oev));
    chk("drop_events_o", 64'(drop_events_o), 64'(m_dev));
    chk("rec_valid_o", 64'(rec_valid_o), 64'(m_q.size() > 0));
    chk("rec_data_o", 64'(rec_data_o), 64'(exp_data));
  endtask

  // Called at a negedge: drive, clock, update model, compare at next negedge.
  task automatic step(input int cnt, input bit v, input bit bc0, input bit clr, input bit rdy);
    cnt_i = CNT_W'(cnt); cnt_valid_i = v; bc0_i = bc0; clear_i = clr; rec_ready_i = rdy;
    @(posedge clock4x);
    model_step(cnt, v, bc0, clr, rdy);
    @(negedge clock4x);
    compare();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    cnt_i = '0; cnt_valid_i = 0; bc0_i = 0; clear_i = 0; rec_ready_i = 0;
    @(posedge clock4x);
    @(negedge clock4x);
    reset = 1'b0;
    model_reset();
    compare();
  endtask

  function automatic int rand_cnt();
    case ($urandom_range(3))
      0:       return int'($urandom_range(3));
      1:       return int'($urandom_range(10, 6));
      2:       return int'($urandom_range(60));
      default: return int'($urandom_range(1536));
    endcase
  endfunction

  initial begin
    model_reset();
    @(negedge clock4x);
    do_reset();

    // Reset values.
    chk("reset overflow_o", 64'(overflow_o), 64'd0);
    chk("reset sticky", 64'(overflow_sticky_o), 64'd0);
    chk("reset max_cnt_o", 64'(max_cnt_o), 64'd0);
    chk("reset ovf_events_o", 64'(ovf_events_o), 64'd0);
    chk("reset drop_events_o", 64'(drop_events_o), 64'd0);
    chk("reset rec_valid_o", 64'(rec_valid_o), 64'd0);
    chk("reset rec_data_o", 64'(rec_data_o), 64'd0);

    // Samples 8, 9, 3.
    step(8, 1, 0, 0, 1);
    chk("ovf after 8", 64'(overflow_o), 64'd0);
    step(9, 1, 0, 0, 1);
    chk("ovf after 9", 64'(overflow_o), 64'd1);
    chk("sticky after 9", 64'(overflow_sticky_o), 64'd1);
    step(3, 1, 0, 0, 1);
    chk("ovf after 3", 64'(overflow_o), 64'd0);
    chk("sticky after 3", 64'(overflow_sticky_o), 64'd1);
    chk("ovf_events after 8,9,3", 64'(ovf_events_o), 64'd1);
    chk("max after 8,9,3", 64'(max_cnt_o), 64'd9);
    step(0, 0, 0, 0, 0);
    chk("ovf holds", 64'(overflow_o), 64'd0);

    // BX tagging across the wrap.
    do_reset();
    step(5, 1, 1, 0, 1);
`ifdef CLUSTER_COUNT_RECORD_FIFO_EN
    chk("bx first record", 64'(rec_data_o), 64'({12'd0, 11'd5}));
`endif
    for (int i = 1; i <= BX_MAX; i++) step(1, 1, 0, 0, 1);
`ifdef CLUSTER_COUNT_RECORD_FIFO_EN
    chk("bx tag at BX_MAX", 64'(rec_data_o[REC_W-1:CNT_W]), 64'd3563);
`endif
    step(1, 1, 0, 0, 1);
`ifdef CLUSTER_COUNT_RECORD_FIFO_EN
    chk("bx tag wrapped", 64'(rec_data_o[REC_W-1:CNT_W]), 64'd0);
`endif
    step(0, 0, 1, 0, 1);   // bc0 without a sample
    step(7, 1, 0, 0, 1);
`ifdef CLUSTER_COUNT_RECORD_FIFO_EN
    chk("bx after lone bc0", 64'(rec_data_o), 64'({12'd0, 11'd7}));
`endif

    // FIFO full: 10 records with no consumer, then drain in order.
    do_reset();
    for (int i = 0; i < 10; i++) step(2, 1, 0, 0, 0);
`ifdef CLUSTER_COUNT_RECORD_FIFO_EN
    chk("full drop_events", 64'(drop_events_o), 64'd2);
    chk("full rec_valid", 64'(rec_valid_o), 64'd1);
    chk("full head record", 64'(rec_data_o), 64'({12'd0, 11'd2}));
`else
    chk("no-fifo drop_events", 64'(drop_events_o), 64'd0);
    chk("no-fifo rec_valid", 64'(rec_valid_o), 64'd0);
`endif
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    chk("drained rec_valid", 64'(rec_valid_o), 64'd0);

    // Simultaneous push and pop at full.
    do_reset();
    for (int i = 0; i < 8; i++) step(3, 1, 0, 0, 0);
    step(4, 1, 0, 0, 1);
`ifdef CLUSTER_COUNT_RECORD_FIFO_EN
    chk("push+pop drop_events", 64'(drop_events_o), 64'd0);
    chk("push+pop head", 64'(rec_data_o), 64'({12'd1, 11'd3}));
`endif
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1);
`ifdef CLUSTER_COUNT_RECORD_FIFO_EN
    chk("push+pop last record", 64'(rec_data_o), 64'({12'd8, 11'd4}));
`endif
    step(0, 0, 0, 0, 1);
    chk("push+pop empty", 64'(rec_valid_o), 64'd0);

    // Clear coinciding with a sample.
    do_reset();
    step(40, 1, 0, 0, 1);
    step(20, 1, 0, 0, 1);
    chk("pre-clear max", 64'(max_cnt_o), 64'd40);
    chk("pre-clear ovf_events", 64'(ovf_events_o), 64'd2);
    step(12, 1, 0, 1, 1);
    chk("clear+sample max", 64'(max_cnt_o), 64'd12);
    chk("clear+sample sticky", 64'(overflow_sticky_o), 64'd1);
    chk("clear+sample ovf_events", 64'(ovf_events_o), 64'd1);
    step(0, 0, 0, 1, 1);
    chk("clear alone sticky", 64'(overflow_sticky_o), 64'd0);
    chk("clear keeps overflow_o", 64'(overflow_o), 64'd1);

    // REC_MIN filter.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    chk("zero samples no record", 64'(rec_valid_o), 64'd0);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999) == 0) do_reset();
      else step(rand_cnt(), $urandom_range(9) < 7, $urandom_range(49) == 0,
                $urandom_range(99) == 0, $urandom_range(2) != 0);
    end

    // Saturation of the overflow event counter.
    do_reset();
    for (int i = 0; i < 65540; i++) step(100, 1, 0, 0, $urandom_range(3) == 0);
    chk("ovf_events saturated", 64'(ovf_events_o), 64'hFFFF);
    chk("sticky after saturation", 64'(overflow_sticky_o), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cluster_count_monitor.md
# cluster_count_monitor

Consumer of the per-sample cluster count produced by the VPF cluster counter. Runs on `clock4x`. Per valid sample it:
- flags overflow against a threshold;
- tracks peak occupancy and counts overflow events;
- tags each sample with a bunch-crossing number;
- queues qualifying count records into a small FIFO, read out with a valid/ready handshake by the readout/monitoring path.

## Interface
- `CNT_W`, 11, count width (max 1536)
- `THRESH`, 8, overflow when count > THRESH
- `REC_MIN`, 1, minimum count that is recorded to the FIFO
- `BX_MAX`, 3563, last BX number before the tag wraps to 0
- `FIFO_DEPTH`, 8, record FIFO depth, power of two
- `EVT_W`, 16, width of the saturating event counters
- `clock4x`  in  1  sole clock; one clock, reset is asynchronous and active-high
- `reset`  in  1  asynchronous active-high reset
- `cnt_i`  in  CNT_W  cluster count sample
- `cnt_valid_i`  in  1  `cnt_i` is a new sample this cycle
- `bc0_i`  in  1  BX-zero marker
- `clear_i`  in  1  synchronous clear of sticky, peak and event counters
- `overflow_o`  out  1  last sample exceeded THRESH
- `overflow_sticky_o`  out  1  any overflow since reset/clear
- `max_cnt_o`  out  CNT_W  peak count since reset/clear
- `ovf_events_o`  out  EVT_W  number of overflowing samples, saturating
- `drop_events_o`  out  EVT_W  records lost to FIFO full, saturating
- `rec_data_o`  out  12+CNT_W  record `{bx_tag[11:0], count}`
- `rec_valid_o`  out  1  record available
- `rec_ready_i`  in  1  consumer accepts record

## Operation
- **BX tag counter (12 b)**
  - Increments on each `cnt_valid_i`.
  - After tagging BX_MAX it wraps to 0.
  - `bc0_i` forces the current sample's tag to 0; the next sample is tagged 1. `bc0_i` without `cnt_valid_i` sets the next sample's tag to 0.
- **Overflow**
  - On `cnt_valid_i`, `overflow_o` <= (`cnt_i` > THRESH). It holds its value between samples.
  - Sticky is set on any overflow sample.
  - `ovf_events_o` increments, saturating at all-ones.
- **Peak**
  - `max_cnt_o` <= max(`max_cnt_o`, `cnt_i`) on valid samples.
- **Clear**
  - `clear_i` zeroes sticky, peak, `ovf_events_o` and `drop_events_o`.
  - If a valid sample arrives in the same cycle, clear wins, then the sample is applied: sticky/peak/events reflect only that sample.
  - `clear_i` does not touch `overflow_o`, the BX tag or the FIFO.
- **Record FIFO**
  - Push when `cnt_valid_i` and `cnt_i` >= REC_MIN.
  - Pop when `rec_valid_o` and `rec_ready_i`.
  - Full with push and no pop: the record is dropped and `drop_events_o` increments (saturating).
  - Full with push and pop in the same cycle: both occur, no drop.
  - Empty with push and `rec_ready_i`: no bypass; the record appears next cycle.
- `rec_data_o` is stable while `rec_valid_o`=1 and `rec_ready_i`=0.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Occupancy = wr-rd.

## Timing
- **Reset values:** all outputs 0; BX tag 0; FIFO empty.
- **Reset mid-operation:** the FIFO is flushed and in-flight records are lost.
- Sample in cycle N → `overflow_o`, sticky, `max_cnt_o`, `ovf_events_o` update at N+1.
- Sample pushed to an empty FIFO in cycle N → `rec_valid_o`=1 at N+1. Latency is 1 cycle.
- Back-to-back samples on every cycle are supported. Throughput is 1 record/cycle with `rec_ready_i` held high.
- `drop_events_o` updates at N+1 after the drop cycle.

## Configuration
- `CLUSTER_COUNT_RECORD_FIFO_EN` defined: the FIFO, handshake and drop counter are built as described.
- Undefined: no FIFO storage. Under this build:
  - `rec_valid_o`=0, `rec_data_o`=0, `drop_events_o`=0, and `rec_ready_i` is ignored.
  - Overflow, peak and BX tagging are unchanged.

## Test plan
- **Reset/overflow:** after reset, samples 8, 9, 3 → `overflow_o` 0, 1, 0. Sticky=1 from the 2nd sample, `ovf_events_o`=1, `max_cnt_o`=9.
- **BX tagging:** `bc0_i` with a sample of 5, then 3563 further valid samples, then one more → tags 0, 1, … 3563, 0. `rec_data_o` of the first record = {12'd0, 11'd5}.
- **FIFO full:** `rec_ready_i`=0, 10 samples of count 2 → 8 records held, `drop_events_o`=2. Then `rec_ready_i`=1 → 8 records in order, then `rec_valid_o`=0.
- **Simultaneous push/pop at full:** FIFO at 8 entries, push and pop in the same cycle → `drop_events_o` unchanged, occupancy stays 8.
- **Clear plus sample:** with `max_cnt_o`=40 and `clear_i` coinciding with a sample of 12 → `max_cnt_o`=12, sticky=1, `ovf_events_o`=1.
- **REC_MIN filter / saturation:** samples of 0 → no records pushed. Forcing 65536 overflow samples → `ovf_events_o` stays at 0xFFFF.
